// File: rtl/tl45_hazard_ctrl_pkg.sv
// Shared definitions for the TL45 pipeline hazard controller: opcodes,
// controller state encoding and register-index type.
package tl45_pkg;

   localparam logic [4:0] OP_NOP  = 5'h00;
   localparam logic [4:0] OP_LBSE = 5'h0F;
   localparam logic [4:0] OP_IN   = 5'h10;
   localparam logic [4:0] OP_LB   = 5'h12;
   localparam logic [4:0] OP_LW   = 5'h14;

   typedef logic [3:0] reg_idx_t;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      HALT  = 2'd2
   } ctrl_state_e;

   // Opcodes whose result arrives through the late writeback port.
   function automatic logic is_late_write(input logic [4:0] op);
      return (op == OP_LBSE) || (op == OP_IN) || (op == OP_LB) || (op == OP_LW);
   endfunction

endpackage

// File: rtl/tl45_hazard_ctrl_if.sv
// Decode-buffer / execute / writeback signals seen by the hazard controller.
// master = pipeline side, slave = controller side.
interface tl45_hazard_ctrl_if;
   import tl45_pkg::*;

   logic [4:0]  i_id_opcode;
   reg_idx_t    i_id_dr;
   reg_idx_t    i_id_sr1;
   reg_idx_t    i_id_sr2;
   logic        i_decode_err;
   logic        i_branch_taken;
   logic        i_wb_valid;
   reg_idx_t    i_wb_dr;
   logic        i_resume;
   logic        o_pipe_stall;
   logic        o_pipe_flush;
   logic        o_issue;
   logic        o_halted;
   logic [15:0] o_pending;

   modport master (
      output i_id_opcode, i_id_dr, i_id_sr1, i_id_sr2, i_decode_err,
             i_branch_taken, i_wb_valid, i_wb_dr, i_resume,
      input  o_pipe_stall, o_pipe_flush, o_issue, o_halted, o_pending
   );

   modport slave (
      input  i_id_opcode, i_id_dr, i_id_sr1, i_id_sr2, i_decode_err,
             i_branch_taken, i_wb_valid, i_wb_dr, i_resume,
      output o_pipe_stall, o_pipe_flush, o_issue, o_halted, o_pending
   );

endinterface

// File: rtl/tl45_hazard_ctrl_scoreboard.sv
// Per-register in-flight counters for long-latency writes. r0 is never
// tracked; an increment and decrement of the same register cancel out.
module tl45_scoreboard
   import tl45_pkg::*;
#(
   parameter int PEND_W = 2
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_inc_en,
   input  reg_idx_t    i_inc_reg,
   input  logic        i_dec_en,
   input  reg_idx_t    i_dec_reg,
   input  reg_idx_t    i_sr1,
   input  reg_idx_t    i_sr2,
   input  reg_idx_t    i_chk_reg,
   output logic        o_sr1_busy,
   output logic        o_sr2_busy,
   output logic        o_chk_sat,
   output logic [15:0] o_pending
);

   localparam logic [PEND_W-1:0] CNT_MAX = '1;

   logic [PEND_W-1:0] cnt_q [16];
   logic [PEND_W-1:0] cnt_d [16];

   always_comb begin
      for (int r = 0; r < 16; r++) begin
         logic inc_hit;
         logic dec_hit;
         inc_hit  = i_inc_en && (i_inc_reg == reg_idx_t'(r)) && (r != 0);
         dec_hit  = i_dec_en && (i_dec_reg == reg_idx_t'(r)) && (r != 0);
         cnt_d[r] = cnt_q[r];
         if (inc_hit && !dec_hit && (cnt_q[r] != CNT_MAX))
            cnt_d[r] = cnt_q[r] + 1'b1;
         else if (dec_hit && !inc_hit && (cnt_q[r] != '0))
            cnt_d[r] = cnt_q[r] - 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      for (int r = 0; r < 16; r++) begin
         if (i_reset)
            cnt_q[r] <= '0;
         else
            cnt_q[r] <= cnt_d[r];
      end
   end

   always_comb begin
      o_sr1_busy = (i_sr1 != '0) && (cnt_q[i_sr1] != '0);
      o_sr2_busy = (i_sr2 != '0) && (cnt_q[i_sr2] != '0);
      o_chk_sat  = (i_chk_reg != '0) && (cnt_q[i_chk_reg] == CNT_MAX);
      o_pending  = '0;
      for (int r = 1; r < 16; r++)
         o_pending[r] = (cnt_q[r] != '0);
   end

endmodule

// File: rtl/tl45_hazard_ctrl.sv
// TL45 pipeline hazard controller: RAW/saturation stalls from the write
// scoreboard, branch flush windows and halt-on-decode-error sequencing.
module tl45_hazard_ctrl
   import tl45_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int PEND_W       = 2
) (
   input logic               i_clk,
   input logic               i_reset,
   tl45_hazard_ctrl_if.slave hz
);

   // fcnt_q holds the FLUSH-state cycles still to run, including the current one.
   localparam logic [2:0] FL_RELOAD = 3'(FLUSH_CYCLES - 1);
   localparam logic [2:0] FL_FULL   = 3'(FLUSH_CYCLES);

   ctrl_state_e state_q, state_d;
   logic [2:0]  fcnt_q, fcnt_d;

   logic valid, late, hazard;
   logic sr1_busy, sr2_busy, dr_sat;
   logic stall, flush, issue, halted;
   logic inc_en, dec_en;

   tl45_scoreboard #(.PEND_W(PEND_W)) u_sb (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_inc_en   (inc_en),
      .i_inc_reg  (hz.i_id_dr),
      .i_dec_en   (dec_en),
      .i_dec_reg  (hz.i_wb_dr),
      .i_sr1      (hz.i_id_sr1),
      .i_sr2      (hz.i_id_sr2),
      .i_chk_reg  (hz.i_id_dr),
      .o_sr1_busy (sr1_busy),
      .o_sr2_busy (sr2_busy),
      .o_chk_sat  (dr_sat),
      .o_pending  (hz.o_pending)
   );

   always_comb begin
      valid   = (hz.i_id_opcode != OP_NOP);
      late    = is_late_write(hz.i_id_opcode);
      hazard  = sr1_busy || sr2_busy || (late && dr_sat);
      stall   = 1'b0;
      flush   = 1'b0;
      issue   = 1'b0;
      halted  = 1'b0;
      state_d = state_q;
      fcnt_d  = fcnt_q;
      case (state_q)
         RUN: begin
            flush = hz.i_branch_taken;
            stall = !flush && valid && hazard;
            issue = valid && !stall && !flush;
            if (hz.i_decode_err) begin
               state_d = HALT;
               fcnt_d  = '0;
            end else if (hz.i_branch_taken) begin
               state_d = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
               fcnt_d  = FL_RELOAD;
            end
         end
         FLUSH: begin
            flush = 1'b1;
            if (hz.i_decode_err) begin
               state_d = HALT;
               fcnt_d  = '0;
            end else if (hz.i_branch_taken) begin
               state_d = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
               fcnt_d  = FL_RELOAD;
            end else if (fcnt_q <= 3'd1) begin
               state_d = RUN;
               fcnt_d  = '0;
            end else begin
               fcnt_d  = fcnt_q - 3'd1;
            end
         end
         HALT: begin
            halted = 1'b1;
            stall  = 1'b1;
            if (hz.i_resume) begin
               state_d = FLUSH;
               fcnt_d  = FL_FULL;
            end
         end
         default: begin
            state_d = RUN;
            fcnt_d  = '0;
         end
      endcase
      inc_en = issue && late;
      dec_en = hz.i_wb_valid;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= RUN;
         fcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
      end
   end

   assign hz.o_pipe_stall = stall;
   assign hz.o_pipe_flush = flush;
   assign hz.o_issue      = issue;
   assign hz.o_halted     = halted;

endmodule

// File: tb/tb_tl45_hazard_ctrl.sv
// Scoreboard bench for tl45_hazard_ctrl: a register-count model predicts the
// outputs of every cycle; a negedge monitor pops and compares them.
module tb_tl45_hazard_ctrl;

   localparam int FC   = 2;
   localparam int PW   = 2;
   localparam int CMAX = (1 << PW) - 1;

   localparam int NOP = 5'h00, ADD = 5'h01, LBSE = 5'h0F, INP = 5'h10, LB = 5'h12, LW = 5'h14;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   tl45_hazard_ctrl_if bus();

   tl45_hazard_ctrl #(.FLUSH_CYCLES(FC), .PEND_W(PW)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .hz      (bus)
   );

   typedef struct {
      logic        stall;
      logic        flush;
      logic        issue;
      logic        halted;
      logic [15:0] pend;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   // Reference model: in-flight counts per register, mode 0=run 1=flush 2=halt,
   // flush_left = flush-mode cycles remaining including the current one.
   int m_cnt[16];
   int m_mode;
   int flush_left;

   function automatic bit is_late(input int op);
      return (op == LBSE) || (op == INP) || (op == LB) || (op == LW);
   endfunction

   task automatic model_reset();
      for (int r = 0; r < 16; r++) m_cnt[r] = 0;
      m_mode     = 0;
      flush_left = 0;
   endtask

   task automatic cyc(input int op, input int dr, input int s1, input int s2,
                      input bit err, input bit br, input bit wbv, input int wbdr,
                      input bit res, input bit r);
      exp_t e;
      bit   valid, raw, sat;
      int   inc, dec;
      @(posedge clk);
      #1;
      bus.i_id_opcode    = 5'(op);
      bus.i_id_dr        = 4'(dr);
      bus.i_id_sr1       = 4'(s1);
      bus.i_id_sr2       = 4'(s2);
      bus.i_decode_err   = err;
      bus.i_branch_taken = br;
      bus.i_wb_valid     = wbv;
      bus.i_wb_dr        = 4'(wbdr);
      bus.i_resume       = res;
      rst                = r;

      valid    = (op != 0);
      e.stall  = 1'b0;
      e.flush  = 1'b0;
      e.issue  = 1'b0;
      e.halted = 1'b0;
      if (m_mode == 0) begin
         raw     = (s1 != 0 && m_cnt[s1] != 0) || (s2 != 0 && m_cnt[s2] != 0);
         sat     = is_late(op) && dr != 0 && m_cnt[dr] == CMAX;
         e.flush = br;
         e.stall = !br && valid && (raw || sat);
         e.issue = valid && !e.stall && !e.flush;
      end else if (m_mode == 1) begin
         e.flush = 1'b1;
      end else begin
         e.stall  = 1'b1;
         e.halted = 1'b1;
      end
      for (int k = 0; k < 16; k++) e.pend[k] = (m_cnt[k] != 0);
      q.push_back(e);

      if (r) begin
         model_reset();
      end else begin
         inc = (e.issue && is_late(op) && dr != 0) ? dr : -1;
         dec = (wbv && wbdr != 0) ? wbdr : -1;
         if (inc != dec) begin
            if (inc >= 0) m_cnt[inc] = m_cnt[inc] + 1;
            if (dec >= 0 && m_cnt[dec] > 0) m_cnt[dec] = m_cnt[dec] - 1;
         end
         if (m_mode == 2) begin
            if (res) begin
               m_mode     = 1;
               flush_left = FC;
            end
         end else if (err) begin
            m_mode = 2;
         end else if (br) begin
            flush_left = FC - 1;
            m_mode     = (flush_left > 0) ? 1 : 0;
         end else if (m_mode == 1) begin
            flush_left = flush_left - 1;
            if (flush_left == 0) m_mode = 0;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic wb(input int reg_n);
      cyc(NOP, 0, 0, 0, 0, 0, 1, reg_n, 0, 0);
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("stall",   16'(bus.o_pipe_stall), 16'(e.stall));
            chk("flush",   16'(bus.o_pipe_flush), 16'(e.flush));
            chk("issue",   16'(bus.o_issue),      16'(e.issue));
            chk("halted",  16'(bus.o_halted),     16'(e.halted));
            chk("pending", bus.o_pending,         e.pend);
         end
      end
   end

   initial begin : stimulus
      int op, dr, s1, s2, wr, sel;
      bus.i_id_opcode    = '0;
      bus.i_id_dr        = '0;
      bus.i_id_sr1       = '0;
      bus.i_id_sr2       = '0;
      bus.i_decode_err   = 1'b0;
      bus.i_branch_taken = 1'b0;
      bus.i_wb_valid     = 1'b0;
      bus.i_wb_dr        = '0;
      bus.i_resume       = 1'b0;
      rst                = 1'b1;
      repeat (2) @(posedge clk);
      model_reset();
      cyc(NOP, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      idle(1);

      // Load-use: ADD r4,r3,r5 waits for the writeback of r3.
      cyc(LW, 3, 1, 2, 0, 0, 0, 0, 0, 0);
      repeat (3) cyc(ADD, 4, 3, 5, 0, 0, 0, 0, 0, 0);
      cyc(ADD, 4, 3, 5, 0, 0, 1, 3, 0, 0);
      cyc(ADD, 4, 3, 5, 0, 0, 0, 0, 0, 0);
      idle(1);

      // Same-cycle issue and writeback on r2 leaves the count at 1.
      cyc(LW, 2, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(LW, 2, 0, 0, 0, 0, 1, 2, 0, 0);
      idle(1);
      wb(2);
      idle(1);

      // Counter saturation on r7; r0 sources never stall.
      repeat (3) cyc(LW, 7, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) cyc(LW, 7, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(ADD, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(LW, 7, 0, 0, 0, 0, 1, 7, 0, 0);
      cyc(LW, 7, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (4) wb(7);
      wb(7);
      idle(1);

      // Branch flush window with a RAW hazard buffered.
      cyc(LW, 9, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(ADD, 4, 9, 0, 0, 1, 0, 0, 0, 0);
      cyc(ADD, 4, 9, 0, 0, 0, 0, 0, 0, 0);
      cyc(ADD, 4, 9, 0, 0, 0, 0, 0, 0, 0);
      cyc(ADD, 4, 9, 0, 0, 0, 1, 9, 0, 0);
      cyc(ADD, 4, 9, 0, 0, 0, 0, 0, 0, 0);

      // Decode error beats branch; writebacks still drain in HALT; resume purges.
      cyc(LW, 6, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(ADD, 1, 0, 0, 1, 1, 0, 0, 0, 0);
      cyc(ADD, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(ADD, 1, 0, 0, 0, 1, 1, 6, 0, 0);
      cyc(ADD, 1, 0, 0, 0, 0, 0, 0, 1, 0);
      repeat (3) cyc(ADD, 1, 0, 0, 0, 0, 0, 0, 0, 0);

      // Reset in the middle of a flush with r5 holding two outstanding loads.
      cyc(LW, 5, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(LW, 5, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(ADD, 1, 5, 0, 0, 1, 0, 0, 0, 0);
      cyc(ADD, 1, 5, 0, 0, 0, 0, 0, 0, 1);
      cyc(ADD, 1, 5, 0, 0, 0, 0, 0, 0, 0);
      idle(1);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         sel = $urandom_range(0, 9);
         if (sel == 0)      op = NOP;
         else if (sel == 1) op = LW;
         else if (sel == 2) op = LB;
         else if (sel == 3) op = INP;
         else if (sel == 4) op = LBSE;
         else               op = $urandom_range(1, 14);
         dr = $urandom_range(0, 7);
         s1 = $urandom_range(0, 7);
         s2 = $urandom_range(0, 7);
         wr = $urandom_range(0, 7);
         if ($urandom_range(0, 1) == 1) begin
            for (int k = 0; k < 8; k++) begin
               int c;
               c = $urandom_range(1, 7);
               if (m_cnt[c] != 0) wr = c;
            end
         end
         cyc(op, dr, s1, s2,
             ($urandom_range(0, 99) == 0),
             ($urandom_range(0, 11) == 0),
             ($urandom_range(0, 2) == 0), wr,
             ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 399) == 0));
      end

      @(negedge clk);
      #1;
      chk("queue_drained", 16'(q.size()), 16'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
